// File: rtl/modexp_sched_pkg.sv
// Shared types and widths for the modular-exponentiation engine scheduler.
package modexp_sched_pkg;

    localparam int unsigned OPW             = 32;
    localparam int unsigned RESW            = 64;
    localparam int unsigned TIMEOUT_DEFAULT = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             found,
    output logic [PW-1:0]    winner
);

    logic [PW-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        // Walk offsets from farthest to nearest so the nearest hit is assigned last.
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx = PW'((32'(ptr) + 32'(i)) % N_REQ);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/modexp_scheduler.sv
// Time-shares one modexp engine between N_REQ requesters with round-robin
// arbitration, a done-wait timeout and a one-cycle response pulse.
module modexp_scheduler
    import modexp_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TW      = 13
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*OPW-1:0]   base_flat,
    input  logic [N_REQ*OPW-1:0]   exp_flat,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [RESW-1:0]        rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   eng_start,
    output logic [OPW-1:0]         eng_base,
    output logic [OPW-1:0]         eng_exp,
    input  logic [RESW-1:0]        eng_result,
    input  logic                   eng_done
);

    localparam int unsigned PW = $clog2(N_REQ);

    sched_state_e state_q, state_d;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [RESW-1:0]  rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic             eng_start_q, eng_start_d;
    logic [OPW-1:0]   eng_base_q, eng_base_d;
    logic [OPW-1:0]   eng_exp_q, eng_exp_d;

    logic             found;
    logic [PW-1:0]    winner;
    logic [N_REQ-1:0] pick_onehot;
    logic [OPW-1:0]   pick_base;
    logic [OPW-1:0]   pick_exp;
    logic             done_ok;
    logic             timed_out;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (found),
        .winner (winner)
    );

    // A done level left over from the previous operation is ignored on the first WAIT cycle.
    assign done_ok   = eng_done && (cnt_q != '0);
    assign timed_out = (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        pick_onehot = '0;
        pick_base   = '0;
        pick_exp    = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (PW'(i) == winner) begin
                pick_onehot[i] = 1'b1;
                pick_base      = base_flat[i*OPW +: OPW];
                pick_exp       = exp_flat[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (done_ok || timed_out) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        eng_start_d = 1'b0;
        eng_base_d  = eng_base_q;
        eng_exp_d   = eng_exp_q;
        busy_d      = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d       = pick_onehot;
                    eng_start_d = 1'b1;
                    eng_base_d  = pick_base;
                    eng_exp_d   = pick_exp;
                    ptr_d       = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
                end
            end
            StIssue: begin
                cnt_d = '0;
            end
            StWait: begin
                cnt_d = cnt_q + TW'(1);
                if (done_ok) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = eng_result;
                    rsp_err_d   = 1'b0;
                end else if (timed_out) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            StResp: begin
                gnt_d = '0;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_base_q  <= '0;
            eng_exp_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
            eng_base_q  <= eng_base_d;
            eng_exp_q   <= eng_exp_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign eng_base  = eng_base_q;
    assign eng_exp   = eng_exp_q;

endmodule

// File: tb/tb_modexp_scheduler.sv
// Bench for modexp_scheduler: engine model, edge-count reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_modexp_scheduler;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    req;
    logic [N*32-1:0] base_flat;
    logic [N*32-1:0] exp_flat;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [63:0]     rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            eng_start;
    logic [31:0]     eng_base;
    logic [31:0]     eng_exp;
    logic [63:0]     eng_result;
    logic            eng_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 0;

    always #5 CLK = ~CLK;

    modexp_scheduler #(
        .N_REQ   (N),
        .TIMEOUT (TO),
        .TW      (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .base_flat  (base_flat),
        .exp_flat   (exp_flat),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_base   (eng_base),
        .eng_exp    (eng_exp),
        .eng_result (eng_result),
        .eng_done   (eng_done)
    );

    function automatic logic [63:0] ipow(input logic [31:0] b, input logic [31:0] e);
        logic [63:0] r;
        logic [63:0] x;
        r = 64'd1;
        x = {32'd0, b};
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = r * x;
            x = x * x;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Engine: result after eng_lat cycles, done held until the next start.
    int          eng_lat   = 10;
    bit          eng_mute  = 0;
    bit          eng_stale = 0;
    int          eng_rem   = 0;
    bit          eng_clr   = 0;
    logic [63:0] eng_pend;

    always @(posedge CLK) begin
        if (RST) begin
            eng_done   <= 1'b0;
            eng_result <= 64'd0;
            eng_rem    <= 0;
            eng_clr    <= 0;
        end else if (eng_start) begin
            eng_rem  <= eng_lat;
            eng_pend <= ipow(eng_base, eng_exp);
            if (eng_stale) eng_clr <= 1;
            else eng_done <= 1'b0;
        end else begin
            if (eng_clr) begin
                eng_done <= 1'b0;
                eng_clr  <= 0;
            end
            if (eng_rem == 1 && !eng_mute) begin
                eng_done   <= 1'b1;
                eng_result <= eng_pend;
            end
            if (eng_rem > 0) eng_rem <= eng_rem - 1;
        end
    end

    // Reference model in terms of edge counts since the grant edge.
    logic [N-1:0] x_gnt, x_rv;
    logic [63:0]  x_data;
    logic         x_err, x_busy, x_start;
    logic [31:0]  x_base, x_exp;
    int           m_ptr   = 0;
    int           m_owner = -1;
    int           m_g     = 0;
    int           m_r     = -1;

    always @(posedge CLK) begin
        cyc++;
        x_rv    = '0;
        x_start = 1'b0;
        if (RST) begin
            x_gnt   = '0;
            x_data  = '0;
            x_err   = 1'b0;
            x_busy  = 1'b0;
            x_base  = '0;
            x_exp   = '0;
            m_ptr   = 0;
            m_owner = -1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < int'(N); k++)
                if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) begin
                m_g     = cyc;
                m_r     = -1;
                x_gnt   = N'(1) << m_owner;
                x_start = 1'b1;
                x_busy  = 1'b1;
                x_base  = base_flat[32*m_owner +: 32];
                x_exp   = exp_flat[32*m_owner +: 32];
                m_ptr   = (m_owner + 1) % N;
            end
        end else if (m_r >= 0) begin
            m_owner = -1;
            x_gnt   = '0;
            x_busy  = 1'b0;
        end else if (cyc >= m_g + 3 && eng_done) begin
            m_r    = cyc;
            x_rv   = x_gnt;
            x_data = eng_result;
            x_err  = 1'b0;
        end else if (cyc == m_g + 1 + int'(TO)) begin
            m_r    = cyc;
            x_rv   = x_gnt;
            x_data = '0;
            x_err  = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("gnt", 64'(gnt), 64'(x_gnt));
            check("rsp_valid", 64'(rsp_valid), 64'(x_rv));
            check("rsp_data", rsp_data, x_data);
            check("rsp_err", 64'(rsp_err), 64'(x_err));
            check("busy", 64'(busy), 64'(x_busy));
            check("eng_start", 64'(eng_start), 64'(x_start));
            check("eng_base", 64'(eng_base), 64'(x_base));
            check("eng_exp", 64'(eng_exp), 64'(x_exp));
            check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            check("rsp_onehot0", 64'($onehot0(rsp_valid)), 64'd1);
        end
    end

    typedef struct {
        logic [N-1:0] v;
        logic [63:0]  d;
        logic         e;
        int           c;
    } rsp_t;
    rsp_t rq[$];

    always @(negedge CLK) begin
        if (rsp_valid != '0) rq.push_back('{v: rsp_valid, d: rsp_data, e: rsp_err, c: cyc});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic get_rsp(output rsp_t r);
        int n = 0;
        r.v = '0;
        r.d = '0;
        r.e = 1'b0;
        r.c = 0;
        while (rq.size() == 0 && n < 60) begin
            tick(1);
            n++;
        end
        if (rq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL rsp_wait at cycle %0d: got no response, expected one within 60 cycles",
                     cyc);
        end else begin
            r = rq.pop_front();
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] b, input logic [31:0] e);
        base_flat[32*i +: 32] = b;
        exp_flat[32*i +: 32]  = e;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req = '0;
        tick(2);
        chk_en = 1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_base", 64'(eng_base), 64'd0);
        RST = 1'b0;
        tick(1);
        rq.delete();
    endtask

    rsp_t r;
    int   t_req;

    initial begin
        RST       = 1'b1;
        req       = '0;
        base_flat = '0;
        exp_flat  = '0;

        // Single request, then fairness with pointer at 1.
        do_reset();
        set_op(0, 5, 3);
        set_op(1, 3, 4);
        set_op(2, 7, 2);
        req   = 3'b001;
        t_req = cyc + 1;
        tick(1);
        check("single_start", 64'(eng_start), 64'd1);
        get_rsp(r);
        req = '0;
        check("single_v", 64'(r.v), 64'b001);
        check("single_d", r.d, 64'd125);
        check("single_e", 64'(r.e), 64'd0);
        check("single_lat", 64'(r.c - t_req), 64'd12);
        tick(1);
        check("single_gnt_clr", 64'(gnt), 64'd0);

        set_op(0, 2, 10);
        req = 3'b111;
        get_rsp(r);
        check("fair0_v", 64'(r.v), 64'b010);
        check("fair0_d", r.d, 64'd81);
        get_rsp(r);
        check("fair1_v", 64'(r.v), 64'b100);
        check("fair1_d", r.d, 64'd49);
        get_rsp(r);
        req = '0;
        check("fair2_v", 64'(r.v), 64'b001);
        check("fair2_d", r.d, 64'd1024);
        tick(3);

        // Simultaneous requests from reset, including the wrap back to 0.
        do_reset();
        req = 3'b111;
        get_rsp(r);
        check("sim0_v", 64'(r.v), 64'b001);
        check("sim0_d", r.d, 64'd1024);
        get_rsp(r);
        check("sim1_v", 64'(r.v), 64'b010);
        check("sim1_d", r.d, 64'd81);
        get_rsp(r);
        check("sim2_v", 64'(r.v), 64'b100);
        check("sim2_d", r.d, 64'd49);
        get_rsp(r);
        req = '0;
        check("sim3_v", 64'(r.v), 64'b001);
        check("sim3_d", r.d, 64'd1024);
        tick(3);

        // Timeout with a silent engine, then a normal service.
        do_reset();
        eng_mute = 1;
        req      = 3'b011;
        t_req    = cyc + 1;
        get_rsp(r);
        req      = 3'b010;
        eng_mute = 0;
        check("to_v", 64'(r.v), 64'b001);
        check("to_e", 64'(r.e), 64'd1);
        check("to_d", r.d, 64'd0);
        check("to_lat", 64'(r.c - t_req), 64'd17);
        get_rsp(r);
        req = '0;
        check("after_to_v", 64'(r.v), 64'b010);
        check("after_to_e", 64'(r.e), 64'd0);
        check("after_to_d", r.d, 64'd81);
        tick(3);

        // Reset mid-WAIT aborts without a response and clears the pointer.
        do_reset();
        set_op(0, 5, 3);
        req = 3'b001;
        tick(1);
        check("abort_start", 64'(eng_start), 64'd1);
        tick(5);
        RST = 1'b1;
        req = '0;
        tick(1);
        check("abort_gnt", 64'(gnt), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rv", 64'(rsp_valid), 64'd0);
        check("abort_base", 64'(eng_base), 64'd0);
        RST = 1'b0;
        check("abort_no_rsp", 64'(rq.size()), 64'd0);
        req = 3'b011;
        tick(1);
        check("abort_ptr0_gnt", 64'(gnt), 64'b001);
        get_rsp(r);
        req = '0;
        check("abort_next_d", r.d, 64'd125);
        tick(3);

        // Request dropped and operands changed right after grant.
        do_reset();
        set_op(0, 6, 2);
        req = 3'b001;
        tick(1);
        check("drop_gnt", 64'(gnt), 64'b001);
        req = '0;
        set_op(0, 99, 7);
        get_rsp(r);
        check("drop_v", 64'(r.v), 64'b001);
        check("drop_d", r.d, 64'd36);
        check("drop_base_hold", 64'(eng_base), 64'd6);
        tick(3);

        // Randomized traffic: latency spanning the timeout, stale done, random resets.
        do_reset();
        for (int it = 0; it < 2500; it++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 7) == 0)
                    set_op(i, $urandom, ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40));
            end
            if ($urandom_range(0, 15) == 0) begin
                eng_lat   = $urandom_range(1, 18);
                eng_mute  = ($urandom_range(0, 7) == 0);
                eng_stale = ($urandom_range(0, 1) == 1);
            end
            RST = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        RST      = 1'b0;
        req      = '0;
        eng_mute = 0;
        tick(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: got no end of test, expected finish before time limit");
        $fatal(1);
    end

endmodule
